dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter MEM_AW, default 30, word-address width of the backing-memory port.
REQ-002 Parameter MAX_WAIT, default 255, cycles without mem_ack before the error flag sets.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pipeline_en  in  1  core pipeline advance; a request is accepted only on an edge where it is 1.
REQ-007 ren  in  1  load request, EX stage.
REQ-008 wen  in  1  store request, EX stage.
REQ-009 addr  in  32  byte address.
REQ-010 rwidth  in  3  load width: 1 = byte, 2 = half, 4 = word.
REQ-011 rsign  in  1  load sign-extend when 1.
REQ-012 wwidth  in  3  store width, same encoding as rwidth.
REQ-013 wdata  in  32  store data, right-aligned.
REQ-014 rdata  out  32  formatted load data, WB stage.
REQ-015 valid  out  1  0 = WB access outstanding, so the core stalls.
REQ-016 mem_req  out  1  backing-memory request.
REQ-017 mem_we  out  1  1 = write.
REQ-018 mem_addr  out  MEM_AW  word address (addr[31:2]).
REQ-019 mem_wstrb  out  4  byte enables.
REQ-020 mem_wdata  out  32  lane-shifted store data.
REQ-021 mem_rdata  in  32  read word.
REQ-022 mem_ack  in  1  completes the current mem_req in the same cycle.
REQ-023 err  out  1  sticky timeout flag.

Function
REQ-024 The FSM SHALL have two states, IDLE and WAIT.
- A request is accepted on an edge where pipeline_en=1 and (ren|wen)=1 with a legal width.
- On acceptance, addr, width, sign, wdata and kind SHALL be registered and the FSM SHALL enter WAIT.
REQ-025 In WAIT, mem_req SHALL be 1, and mem_addr, mem_we, mem_wstrb and mem_wdata SHALL be driven from the registers and stay stable until mem_ack.
REQ-026 valid SHALL equal (state==IDLE) | (state==WAIT & mem_ack).
- valid SHALL NOT depend combinationally on pipeline_en, ren or wen.
REQ-027 On a WAIT edge with mem_ack=1:
- if a new request is accepted on the same edge, the FSM SHALL stay in WAIT with the new request;
- otherwise it SHALL go to IDLE.
REQ-028 Latency: with zero-wait memory (mem_ack=1 in the first WAIT cycle), back-to-back accesses SHALL complete with no stall cycles.
REQ-029 While valid=0, inputs SHALL NOT be re-sampled.
REQ-030 When ren and wen are both 1, the store SHALL be performed and rdata SHALL be 0.
REQ-031 Store strobes:
- byte: wstrb = 1<<addr[1:0], data replicated to all lanes;
- half: wstrb = 4'b0011<<(2*addr[1]), addr[0] ignored;
- word: wstrb = 4'b1111, addr[1:0] ignored.
REQ-032 Loads SHALL select the lane by the registered addr, then zero- or sign-extend per rsign; rdata is valid only while valid=1 and the access was a load.
REQ-033 An illegal width (0, 3, 5-7) SHALL NOT be accepted: no mem_req, FSM stays in IDLE, valid=1.
REQ-034 rdata SHALL be 0 whenever no load completes in the current cycle.
REQ-035 A wait counter SHALL increment in WAIT, clear on mem_ack, and saturate.
- Reaching MAX_WAIT SHALL set err, which stays set until rst.
- The access continues to wait after err sets.
REQ-036 mem_ack while in IDLE SHALL be ignored.

Reset
REQ-037 rst SHALL force IDLE, mem_req=0, valid=1, rdata=0, mem_wstrb=0, err=0 and wait counter=0.
REQ-038 rst mid-WAIT SHALL abandon the access: mem_req drops the next cycle and no write-back is reported.

Structure
REQ-039 Width encodings (1/2/4) SHALL live in the shared defs package, alongside the existing mem_ctrl constants.
REQ-040 Lane alignment and extension SHALL be one combinational sub-module, lsu_align, used for both store strobes/data and load formatting.
REQ-041 The FSM and counter SHALL stay in dmem_resp.

Verification
REQ-042 Word load, addr=0x100, mem_rdata=0x8899AABB, ack in the first WAIT cycle -> mem_addr=0x40, rdata=0x8899AABB, no valid=0 cycle.
REQ-043 Signed byte load, addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-044 Half store, addr=0x202, wdata=0x0000BEEF -> mem_wstrb=4'b1100, mem_wdata[31:16]=0xBEEF, mem_we=1.
REQ-045 Three wait cycles before mem_ack -> valid=0 for exactly 3 cycles, mem_addr stable, and exactly one access issued.
REQ-046 rst asserted in the second WAIT cycle -> mem_req=0 the next cycle, valid=1, and a later stray mem_ack is ignored.
REQ-047 No ack for MAX_WAIT cycles -> err=1, and err stays 1 after a subsequent ack until rst.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared data-memory definitions: access width encodings, memory-controller
// constants and the registered request payload used by dmem_resp.
package dmem_resp_pkg;

  localparam int unsigned MEM_CTRL_DATA_W   = 32;
  localparam int unsigned MEM_CTRL_STRB_W   = MEM_CTRL_DATA_W / 8;
  localparam int unsigned MEM_CTRL_WORD_LSB = 2;

  // Access width encodings shared by rwidth and wwidth
  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmem_state_e;

  typedef struct packed {
    logic [MEM_CTRL_DATA_W-1:0] addr;
    logic [2:0]                 width;
    logic                       sign;
    logic                       we;
    logic [MEM_CTRL_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic is_legal_width(logic [2:0] w);
    return (w == WIDTH_BYTE) || (w == WIDTH_HALF) || (w == WIDTH_WORD);
  endfunction

endpackage

// File: rtl/dmem_resp_lsu_align.sv
// Byte-lane alignment: store strobes and lane-replicated store data, plus
// lane selection and zero/sign extension of load data.
module lsu_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]                 addr_lo,
  input  logic [2:0]                 width,
  input  logic                       sign,
  input  logic [MEM_CTRL_DATA_W-1:0] wdata,
  input  logic [MEM_CTRL_DATA_W-1:0] rdata_word,
  output logic [MEM_CTRL_STRB_W-1:0] wstrb_c,
  output logic [MEM_CTRL_DATA_W-1:0] wdata_c,
  output logic [MEM_CTRL_DATA_W-1:0] rdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_word[{addr_lo, 3'b000} +: 8];
    half_sel = rdata_word[{addr_lo[1], 4'b0000} +: 16];
  end

  always_comb begin
    wstrb_c = '0;
    wdata_c = '0;
    rdata_c = '0;
    case (width)
      WIDTH_BYTE: begin
        wstrb_c = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      WIDTH_HALF: begin
        // addr[0] is ignored for halfword accesses
        wstrb_c = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = {{16{sign & half_sel[15]}}, half_sel};
      end
      WIDTH_WORD: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
        rdata_c = rdata_word;
      end
      default: begin
        wstrb_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory response unit: accepts one load/store per pipeline advance,
// holds it on the backing-memory port until mem_ack and formats the reply.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned MEM_AW   = 30,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipeline_en,
  input  logic              ren,
  input  logic              wen,
  input  logic [31:0]       addr,
  input  logic [2:0]        rwidth,
  input  logic              rsign,
  input  logic [2:0]        wwidth,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  dmem_state_e      state_q, state_d;
  dmem_req_t        req_q, req_d, req_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [2:0]       acc_width;
  logic             done_c;
  logic             accept_c;
  logic [3:0]       align_wstrb;
  logic [31:0]      align_wdata;
  logic [31:0]      align_rdata;

  // A store wins when ren and wen are both set, so its width decides legality
  assign acc_width = wen ? wwidth : rwidth;
  assign done_c    = (state_q == ST_WAIT) & mem_ack;
  assign valid     = (state_q == ST_IDLE) | done_c;
  assign accept_c  = valid & pipeline_en & (ren | wen) & is_legal_width(acc_width);

  always_comb begin
    req_new       = '0;
    req_new.addr  = addr;
    req_new.width = acc_width;
    req_new.sign  = rsign & ~wen;
    req_new.we    = wen;
    req_new.wdata = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_WAIT;
          req_d   = req_new;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          cnt_d = '0;
          if (accept_c) begin
            req_d = req_new;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // Saturating stall counter; err is sticky and the access keeps waiting
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          err_d = err_q | (cnt_d == CNT_MAX);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  lsu_align u_align (
    .addr_lo    (req_q.addr[1:0]),
    .width      (req_q.width),
    .sign       (req_q.sign),
    .wdata      (req_q.wdata),
    .rdata_word (mem_rdata),
    .wstrb_c    (align_wstrb),
    .wdata_c    (align_wdata),
    .rdata_c    (align_rdata)
  );

  assign mem_req   = (state_q == ST_WAIT);
  assign mem_we    = mem_req & req_q.we;
  assign mem_addr  = MEM_AW'(req_q.addr[31:MEM_CTRL_WORD_LSB]);
  assign mem_wstrb = mem_we ? align_wstrb : 4'b0000;
  assign mem_wdata = align_wdata;
  assign rdata     = (done_c & ~req_q.we) ? align_rdata : 32'h0;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp with a behavioural memory model
// and directed boundary cases.
module tb_dmem_resp;

  localparam int MAX_WAIT = 20;

  logic        clk, rst, pipeline_en, ren, wen, rsign;
  logic [31:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic [2:0]  rwidth, wwidth;
  logic        valid, mem_req, mem_we, mem_ack, err;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;

  dmem_resp #(.MEM_AW(30), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .ren(ren), .wen(wen),
    .addr(addr), .rwidth(rwidth), .rsign(rsign), .wwidth(wwidth), .wdata(wdata),
    .rdata(rdata), .valid(valid), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] maddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_valid_low = 0;
  int          n_acc = 0;
  logic [31:0] ref_mem[int];
  logic [31:0] phy_mem[int];
  logic [31:0] last_rdata, last_wdata;
  logic [3:0]  last_strb;
  logic        last_we;
  bit          auto_resp = 1'b1;
  int          force_wait = -1;
  int          wcnt = 0;
  int          target = 0;
  bit          prev_wait = 1'b0;
  logic [29:0] prev_addr;
  logic [3:0]  prev_strb;
  logic        prev_we;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(int a);
    return 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] get_ref(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] get_phy(int a);
    return phy_mem.exists(a) ? phy_mem[a] : init_word(a);
  endfunction

  // Reference model: what the memory port and write-back should show for one access
  task automatic push_expected(logic w, logic [31:0] a, logic [2:0] rw, logic rs,
                               logic [2:0] ww, logic [31:0] wd);
    exp_t        e;
    int          wa, off, v;
    logic [31:0] word;
    wa = int'(a >> 2);
    off = int'(a % 4);
    e.we = w;
    e.maddr = a[31:2];
    e.wstrb = 4'b0000;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    if (w) begin
      word = get_ref(wa);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        bit hit;
        hit = (ww == 3'd4) || (ww == 3'd1 && k == off) || (ww == 3'd2 && k / 2 == off / 2);
        if (ww == 3'd1)      b = wd[7:0];
        else if (ww == 3'd2) b = wd[8*(k%2) +: 8];
        else                 b = wd[8*k +: 8];
        if (hit) begin
          e.wstrb[k] = 1'b1;
          e.wdata[8*k +: 8] = b;
          word[8*k +: 8] = b;
        end
      end
      ref_mem[wa] = word;
    end else begin
      word = get_ref(wa);
      if (rw == 3'd1) begin
        v = int'((word >> (8 * off)) & 32'hFF);
        if (rs && v >= 128) v = v - 256;
        e.rdata = 32'(v);
      end else if (rw == 3'd2) begin
        v = int'((word >> (16 * (off / 2))) & 32'hFFFF);
        if (rs && v >= 32768) v = v - 65536;
        e.rdata = 32'(v);
      end else begin
        e.rdata = word;
      end
    end
    sb_q.push_back(e);
  endtask

  // Present a request and hold it until the DUT can take it
  task automatic issue(logic r, logic w, logic [31:0] a, logic [2:0] rw, logic rs,
                       logic [2:0] ww, logic [31:0] wd, logic pen0);
    logic [2:0] aw;
    bit         legal;
    @(posedge clk); #1;
    ren = r; wen = w; addr = a; rwidth = rw; rsign = rs; wwidth = ww; wdata = wd;
    pipeline_en = pen0;
    aw = w ? ww : rw;
    legal = (r || w) && (aw == 3'd1 || aw == 3'd2 || aw == 3'd4);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (valid && pipeline_en) begin
        if (legal) push_expected(w, a, rw, rs, ww, wd);
        return;
      end
      @(posedge clk); #1;
      pipeline_en = 1'b1;
    end
    n_checks++; n_fail++;
    $display("FAIL issue_timeout: request at 0x%08h never accepted", a);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ren = 1'b0; wen = 1'b0; pipeline_en = 1'b1;
    end
  endtask

  task automatic drain();
    int cyc;
    idle(1);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_queue", 32'(sb_q.size()), 32'h0);
    idle(1);
  endtask

  // Backing memory with a random (or forced) number of wait cycles
  always @(posedge clk) begin
    #2;
    if (auto_resp) begin
      if (mem_req) begin
        if (wcnt >= target) begin
          logic [31:0] w;
          mem_ack = 1'b1;
          mem_rdata = get_phy(int'(mem_addr));
          if (mem_we) begin
            w = get_phy(int'(mem_addr));
            for (int k = 0; k < 4; k++)
              if (mem_wstrb[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
            phy_mem[int'(mem_addr)] = w;
          end
          wcnt = 0;
          target = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever an access completes
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 32'(valid), 32'(!mem_req || mem_ack));
      if (!valid) n_valid_low++;
      if (mem_req && mem_ack) begin
        logic [31:0] mask;
        n_acc++;
        last_rdata = rdata; last_wdata = mem_wdata; last_strb = mem_wstrb; last_we = mem_we;
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_access: addr 0x%08h, expected none", mem_addr);
        end else begin
          mon_e = sb_q.pop_front();
          for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{mon_e.wstrb[k]}};
          check("mem_we", 32'(mem_we), 32'(mon_e.we));
          check("mem_addr", 32'(mem_addr), 32'(mon_e.maddr));
          check("mem_wstrb", 32'(mem_wstrb), 32'(mon_e.wstrb));
          if (mon_e.we) check("mem_wdata", mem_wdata & mask, mon_e.wdata);
          check("rdata", rdata, mon_e.rdata);
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
      if (prev_wait && mem_req) begin
        check("stable_addr", 32'(mem_addr), 32'(prev_addr));
        check("stable_strb", 32'(mem_wstrb), 32'(prev_strb));
        check("stable_we", 32'(mem_we), 32'(prev_we));
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr; prev_strb = mem_wstrb; prev_we = mem_we;
    end else begin
      prev_wait = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pipeline_en = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0;
    rwidth = 3'd4; rsign = 1'b0; wwidth = 3'd4; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'h1);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; pipeline_en = 1'b1;

    // Illegal widths are never accepted
    @(posedge clk); #1;
    ren = 1'b1; rwidth = 3'd3;
    @(negedge clk);
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b1; wwidth = 3'd0;
    @(negedge clk);
    check("illegal_no_req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    wen = 1'b0;
    @(negedge clk);
    check("illegal_no_req2", 32'(mem_req), 32'h0);
    check("illegal_valid", 32'(valid), 32'h1);

    // Zero-wait word loads back to back
    force_wait = 0; target = 0;
    ref_mem[32'h40] = 32'h8899_AABB; phy_mem[32'h40] = 32'h8899_AABB;
    n_valid_low = 0;
    issue(1, 0, 32'h100, 3'd4, 0, 3'd4, 0, 1);
    issue(1, 0, 32'h104, 3'd4, 0, 3'd4, 0, 1);
    issue(1, 0, 32'h100, 3'd4, 0, 3'd4, 0, 1);
    drain();
    check("word_load_rdata", last_rdata, 32'h8899_AABB);
    check("zero_wait_no_stall", 32'(n_valid_low), 32'h0);

    // Signed and unsigned byte loads from lane 3
    ref_mem[32'h40] = 32'h8011_2233; phy_mem[32'h40] = 32'h8011_2233;
    issue(1, 0, 32'h103, 3'd1, 1, 3'd4, 0, 1);
    drain();
    check("byte_load_signed", last_rdata, 32'hFFFF_FF80);
    issue(1, 0, 32'h103, 3'd1, 0, 3'd4, 0, 1);
    drain();
    check("byte_load_unsigned", last_rdata, 32'h0000_0080);

    // Halfword store to the upper half
    issue(0, 1, 32'h202, 3'd4, 0, 3'd2, 32'h0000_BEEF, 1);
    drain();
    check("half_store_strb", 32'(last_strb), 32'hC);
    check("half_store_data", 32'(last_wdata[31:16]), 32'h0000_BEEF);
    check("half_store_we", 32'(last_we), 32'h1);

    // Three wait states: exactly three stall cycles and a single access
    force_wait = 3; target = 3;
    n_valid_low = 0; n_acc = 0;
    issue(1, 0, 32'h108, 3'd4, 0, 3'd4, 0, 1);
    drain();
    check("wait3_stall_cycles", 32'(n_valid_low), 32'h3);
    check("wait3_one_access", 32'(n_acc), 32'h1);

    // Randomized traffic
    force_wait = -1;
    for (int t = 0; t < 300; t++) begin
      int          kind;
      logic [31:0] a;
      logic [2:0]  w1, w2;
      kind = int'($urandom_range(0, 9));
      a = 32'h100 + 32'($urandom_range(0, 63));
      w1 = 3'(1 << $urandom_range(0, 2));
      w2 = 3'(1 << $urandom_range(0, 2));
      case (kind)
        0, 1, 2, 3: issue(1, 0, a, w1, 1'($urandom), w2, $urandom, 1'($urandom_range(0, 3) != 0));
        4, 5, 6, 7: issue(0, 1, a, w1, 1'($urandom), w2, $urandom, 1'($urandom_range(0, 3) != 0));
        8:          issue(1, 1, a, w1, 1'($urandom), w2, $urandom, 1'b1);
        default:    issue(1, 0, a, 3'd3 + 3'($urandom_range(0, 1) * 2), 1'b0, w2, $urandom, 1'b1);
      endcase
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Reset in the second wait cycle abandons the access
    auto_resp = 1'b0;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    issue(1, 0, 32'h108, 3'd4, 0, 3'd4, 0, 1);
    idle(1);
    @(posedge clk); #1;
    ren = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_wait_mem_req", 32'(mem_req), 32'h0);
    check("rst_wait_valid", 32'(valid), 32'h1);
    check("rst_wait_rdata", rdata, 32'h0);
    @(posedge clk); #2;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_ack_rdata", rdata, 32'h0);
    check("stray_ack_valid", 32'(valid), 32'h1);
    @(posedge clk); #2;
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_no_req", 32'(mem_req), 32'h0);

    // Timeout flag after MAX_WAIT cycles without ack, sticky until reset
    issue(1, 0, 32'h10C, 3'd4, 0, 3'd4, 0, 1);
    for (int i = 0; i < MAX_WAIT; i++) begin
      idle(1);
      @(negedge clk);
      check("err_early", 32'(err), 32'h0);
    end
    idle(1);
    @(negedge clk);
    check("err_set", 32'(err), 32'h1);
    check("err_still_waiting", 32'(mem_req), 32'h1);
    @(posedge clk); #2;
    mem_ack = 1'b1; mem_rdata = get_ref(32'h10C >> 2);
    @(posedge clk); #2;
    mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", 32'(err), 32'h1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
